// File: rtl/exu_pkg.sv
// rtl/exu_pkg.sv - shared op-class, state and ALU encodings for the EXU sequencer
package exu_pkg;

  typedef enum logic [3:0] {
    OP_R      = 4'd0,
    OP_I      = 4'd1,
    OP_LUI    = 4'd2,
    OP_AUIPC  = 4'd3,
    OP_LOAD   = 4'd4,
    OP_STORE  = 4'd5,
    OP_BRANCH = 4'd6,
    OP_JAL    = 4'd7,
    OP_JALR   = 4'd8,
    OP_MULDIV = 4'd9,
    OP_SYSTEM = 4'd10
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EXEC     = 3'd1,
    ST_MDU_WAIT = 3'd2,
    ST_MEM_WAIT = 3'd3,
    ST_HALT     = 3'd4
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  // funct3 of srl/sra (and srli/srai); the only I-type op where f7b5 matters
  localparam logic [2:0] F3_SR   = 3'b101;

endpackage

// File: rtl/exu_ctrl_dec.sv
// rtl/exu_ctrl_dec.sv - combinational decode of latched op fields into EXU datapath selects
module exu_ctrl_dec
  import exu_pkg::*;
(
  input  logic [3:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic       i_f7b5,
  output logic [2:0] o_alu_ctrl,
  output logic       o_alu_sub,
  output logic       o_alu_s1_sel,
  output logic       o_alu_s2_sel,
  output logic       o_branch_and,
  output logic       o_branch_add4,
  output logic       o_branch_src,
  output logic       o_lsu_we
);

  // Per-op-class select table; unknown classes fall through to an add/pc+4 nop shape
  always_comb begin
    o_alu_ctrl    = ALU_ADD;
    o_alu_sub     = 1'b0;
    o_alu_s1_sel  = 1'b0;
    o_alu_s2_sel  = 1'b0;
    o_branch_and  = 1'b0;
    o_branch_add4 = 1'b1;
    o_branch_src  = 1'b0;
    o_lsu_we      = 1'b0;
    case (i_op)
      OP_R: begin
        o_alu_ctrl = i_funct3;
        o_alu_sub  = i_f7b5;
      end
      OP_I: begin
        o_alu_ctrl   = i_funct3;
        // addi has no subtract form; imm bit 10 only selects srai
        o_alu_sub    = i_f7b5 && (i_funct3 == F3_SR);
        o_alu_s2_sel = 1'b1;
      end
      OP_LUI:   o_alu_s2_sel = 1'b1;
      OP_AUIPC: begin
        o_alu_s1_sel = 1'b1;
        o_alu_s2_sel = 1'b1;
      end
      OP_LOAD:  o_alu_s2_sel = 1'b1;
      OP_STORE: begin
        o_alu_s2_sel = 1'b1;
        o_lsu_we     = 1'b1;
      end
      OP_BRANCH: begin
        o_alu_sub    = 1'b1;
        o_branch_and = 1'b1;
      end
      OP_JAL: begin
        o_alu_s1_sel  = 1'b1;
        o_branch_add4 = 1'b0;
      end
      OP_JALR: begin
        o_alu_s2_sel  = 1'b1;
        o_branch_add4 = 1'b0;
        o_branch_src  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/exu_seq_ctrl.sv
// rtl/exu_seq_ctrl.sv - EXU multi-cycle sequencer: accept, exec, MDU/LSU waits, commit, halt
module exu_seq_ctrl
  import exu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_op,
  input  logic [2:0] in_funct3,
  input  logic       in_f7b5,
  output logic [2:0] alu_ctrl,
  output logic       alu_sub,
  output logic       alu_s1_sel,
  output logic       alu_s2_sel,
  output logic       branch_and,
  output logic       branch_add4,
  output logic       branch_src,
  output logic       mdu_start,
  input  logic       mdu_done,
  output logic       lsu_req,
  output logic       lsu_we,
  input  logic       lsu_ack,
  output logic       rf_we,
  output logic       pc_we,
  output logic       commit,
  output logic       exc,
  output logic       halted
);

  // Counter holds (wait cycles already spent); the limit cycle is the TIMEOUT_CYC-th wait cycle
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

  state_e           r_state;
  state_e           w_next;
  logic [3:0]       r_op;
  logic [2:0]       r_funct3;
  logic             r_f7b5;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_active;
  logic             w_limit;
  logic [2:0]       w_alu_ctrl;
  logic             w_alu_sub;
  logic             w_s1_sel;
  logic             w_s2_sel;
  logic             w_b_and;
  logic             w_b_add4;
  logic             w_b_src;
  logic             w_lsu_we;

  assign w_accept = in_valid && (r_state == ST_IDLE);
  assign w_active = (r_state == ST_EXEC) || (r_state == ST_MDU_WAIT) ||
                    (r_state == ST_MEM_WAIT);
  assign w_limit  = (r_cnt == LIMIT);

  exu_ctrl_dec u_dec (
    .i_op          (r_op),
    .i_funct3      (r_funct3),
    .i_f7b5        (r_f7b5),
    .o_alu_ctrl    (w_alu_ctrl),
    .o_alu_sub     (w_alu_sub),
    .o_alu_s1_sel  (w_s1_sel),
    .o_alu_s2_sel  (w_s2_sel),
    .o_branch_and  (w_b_and),
    .o_branch_add4 (w_b_add4),
    .o_branch_src  (w_b_src),
    .o_lsu_we      (w_lsu_we)
  );

  // Datapath selects are only meaningful while an instruction is in flight
  assign alu_ctrl    = w_active ? w_alu_ctrl : 3'b000;
  assign alu_sub     = w_active & w_alu_sub;
  assign alu_s1_sel  = w_active & w_s1_sel;
  assign alu_s2_sel  = w_active & w_s2_sel;
  assign branch_and  = w_active & w_b_and;
  assign branch_add4 = w_active & w_b_add4;
  assign branch_src  = w_active & w_b_src;
  assign lsu_we      = w_active & w_lsu_we;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Capture the decoded instruction fields on the accept handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op     <= 4'd0;
      r_funct3 <= 3'd0;
      r_f7b5   <= 1'b0;
    end else if (w_accept) begin
      r_op     <= in_op;
      r_funct3 <= in_funct3;
      r_f7b5   <= in_f7b5;
    end
  end

  // Wait-cycle counter: cleared in EXEC so it starts at 0 on the first wait cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                                     r_cnt <= '0;
    else if (r_state == ST_EXEC)                                  r_cnt <= '0;
    else if (r_state == ST_MDU_WAIT || r_state == ST_MEM_WAIT)    r_cnt <= r_cnt + 1'b1;
  end

  // Next-state and handshake/commit outputs
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    mdu_start = 1'b0;
    lsu_req   = 1'b0;
    rf_we     = 1'b0;
    pc_we     = 1'b0;
    commit    = 1'b0;
    exc       = 1'b0;
    halted    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (w_accept) w_next = ST_EXEC;
      end
      ST_EXEC: begin
        case (r_op)
          OP_MULDIV: begin
            mdu_start = 1'b1;
            w_next    = ST_MDU_WAIT;
          end
          OP_LOAD, OP_STORE: begin
            lsu_req = 1'b1;
            w_next  = ST_MEM_WAIT;
          end
          OP_SYSTEM: w_next = ST_HALT;
          OP_R, OP_I, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
            commit = 1'b1;
            pc_we  = 1'b1;
            rf_we  = 1'b1;
            w_next = ST_IDLE;
          end
          default: begin
            // BRANCH and unknown classes retire without a writeback
            commit = 1'b1;
            pc_we  = 1'b1;
            w_next = ST_IDLE;
          end
        endcase
      end
      ST_MDU_WAIT: begin
        if (mdu_done) begin
          commit = 1'b1;
          pc_we  = 1'b1;
          rf_we  = 1'b1;
          w_next = ST_IDLE;
        end else if (w_limit) begin
          commit = 1'b1;
          pc_we  = 1'b1;
          exc    = 1'b1;
          w_next = ST_IDLE;
        end
      end
      ST_MEM_WAIT: begin
        lsu_req = 1'b1;
        if (lsu_ack) begin
          commit = 1'b1;
          pc_we  = 1'b1;
          rf_we  = (r_op == OP_LOAD);
          w_next = ST_IDLE;
        end else if (w_limit) begin
          lsu_req = 1'b0;
          commit  = 1'b1;
          pc_we   = 1'b1;
          exc     = 1'b1;
          w_next  = ST_IDLE;
        end
      end
      ST_HALT:  halted = 1'b1;
      default:  w_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_exu_seq_ctrl.sv
// tb/tb_exu_seq_ctrl.sv - directed self-checking bench for exu_seq_ctrl
module tb_exu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_op = 4'd0;
  logic [2:0] in_funct3 = 3'd0;
  logic       in_f7b5 = 1'b0;
  logic [2:0] alu_ctrl;
  logic       alu_sub, alu_s1_sel, alu_s2_sel;
  logic       branch_and, branch_add4, branch_src;
  logic       mdu_start;
  logic       mdu_done = 1'b0;
  logic       lsu_req, lsu_we;
  logic       lsu_ack = 1'b0;
  logic       rf_we, pc_we, commit, exc, halted;

  int n_checks = 0;
  int n_errors = 0;
  int req_cnt;

  exu_seq_ctrl #(.TIMEOUT_CYC(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_funct3(in_funct3), .in_f7b5(in_f7b5),
    .alu_ctrl(alu_ctrl), .alu_sub(alu_sub),
    .alu_s1_sel(alu_s1_sel), .alu_s2_sel(alu_s2_sel),
    .branch_and(branch_and), .branch_add4(branch_add4), .branch_src(branch_src),
    .mdu_start(mdu_start), .mdu_done(mdu_done),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_ack(lsu_ack),
    .rf_we(rf_we), .pc_we(pc_we), .commit(commit), .exc(exc), .halted(halted)
  );

  always #5 clk = ~clk;

  wire [18:0] w_outs = {alu_ctrl, alu_sub, alu_s1_sel, alu_s2_sel, branch_and,
                        branch_add4, branch_src, mdu_start, lsu_req, lsu_we,
                        rf_we, pc_we, commit, exc, halted};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction in IDLE; returns settled in the EXEC cycle
  task automatic accept(input logic [3:0] op, input logic [2:0] f3, input logic f7);
    in_valid  = 1'b1;
    in_op     = op;
    in_funct3 = f3;
    in_f7b5   = f7;
    #1;
    check("accept_ready", in_ready, 1);
    cyc();
    in_valid = 1'b0;
    #1;
  endtask

  initial begin
    // Reset state
    cyc(); cyc();
    check("rst_ready", in_ready, 1);
    check("rst_outs", w_outs, 0);
    rst = 1'b1;
    cyc(); #1;

    // R sub: funct3=000, f7b5=1
    accept(4'd0, 3'b000, 1'b1);
    check("r_ctrl", alu_ctrl, 0);
    check("r_sub", alu_sub, 1);
    check("r_commit", {commit, pc_we, rf_we, exc}, 4'b1110);
    check("r_s2", alu_s2_sel, 0);
    check("r_busy", in_ready, 0);
    cyc(); #1;
    check("r_idle", {in_ready, commit}, 2'b10);

    // I srai: sub honoured; addi with f7b5=1: sub ignored
    accept(4'd1, 3'b101, 1'b1);
    check("srai_dec", {alu_ctrl, alu_sub, alu_s2_sel}, 5'b10111);
    cyc(); #1;
    accept(4'd1, 3'b000, 1'b1);
    check("addi_dec", {alu_ctrl, alu_sub, alu_s2_sel, rf_we}, 6'b000011);
    cyc(); #1;

    // BRANCH: compare-subtract, no writeback
    accept(4'd6, 3'b001, 1'b0);
    check("br_dec", {alu_sub, branch_and, branch_add4, branch_src}, 4'b1110);
    check("br_commit", {commit, pc_we, rf_we}, 3'b110);
    cyc(); #1;

    // AUIPC selects pc and imm
    accept(4'd3, 3'b000, 1'b0);
    check("auipc_dec", {alu_s1_sel, alu_s2_sel, rf_we}, 3'b111);
    cyc(); #1;

    // Unknown op retires as nop
    accept(4'd15, 3'b000, 1'b0);
    check("unk_commit", {commit, pc_we, rf_we, exc}, 4'b1100);
    cyc(); #1;

    // LOAD: ack in EXEC ignored, real ack 3 cycles after EXEC
    accept(4'd4, 3'b010, 1'b0);
    req_cnt = 0;
    lsu_ack = 1'b1;
    #1;
    check("ld_exec_nocommit", commit, 0);
    check("ld_exec_dec", {lsu_req, lsu_we, alu_s2_sel}, 3'b101);
    if (lsu_req) req_cnt++;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      lsu_ack = (i == 3);
      #1;
      if (lsu_req) req_cnt++;
      if (i < 3) check("ld_wait", commit, 0);
    end
    check("ld_commit", {commit, rf_we, pc_we, exc}, 4'b1110);
    check("ld_req_cycles", req_cnt, 4);
    cyc();
    lsu_ack = 1'b0;
    #1;
    check("ld_idle", {in_ready, lsu_req}, 2'b10);

    // STORE timeout: exc on 4th wait cycle, request dropped
    accept(4'd5, 3'b010, 1'b0);
    check("st_exec", {lsu_req, lsu_we, commit}, 3'b110);
    for (int i = 1; i <= 3; i++) begin
      cyc(); #1;
      check("st_wait", {commit, lsu_req}, 2'b01);
    end
    cyc(); #1;
    check("st_timeout", {commit, exc, pc_we, rf_we, lsu_req}, 5'b11100);
    cyc(); #1;
    check("st_idle", in_ready, 1);

    // LOAD with ack on the limit cycle: normal commit wins
    accept(4'd4, 3'b010, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      lsu_ack = (i == 4);
      #1;
    end
    check("ld_lim_commit", {commit, exc, rf_we, lsu_req}, 4'b1011);
    cyc();
    lsu_ack = 1'b0;
    #1;

    // MULDIV: start in EXEC, done 2 cycles later
    accept(4'd9, 3'b000, 1'b1);
    check("md_start", {mdu_start, commit}, 2'b10);
    cyc(); #1;
    check("md_wait", {mdu_start, commit}, 2'b00);
    cyc();
    mdu_done = 1'b1;
    #1;
    check("md_commit", {commit, rf_we, pc_we, exc}, 4'b1110);
    cyc();
    mdu_done = 1'b0;
    #1;
    check("md_idle", in_ready, 1);

    // Reset asserted mid MEM_WAIT
    accept(4'd4, 3'b010, 1'b0);
    cyc(); #1;
    check("mw_req", lsu_req, 1);
    rst = 1'b0;
    #1;
    check("mw_rst_async", {in_ready, lsu_req, commit}, 3'b100);
    cyc(); #1;
    check("mw_rst_outs", w_outs, 0);
    check("mw_rst_ready", in_ready, 1);
    rst = 1'b1;
    cyc(); #1;

    // JALR then SYSTEM: halt is sticky until reset
    accept(4'd8, 3'b000, 1'b0);
    check("jalr_dec", {branch_src, branch_add4, alu_s2_sel, rf_we}, 4'b1011);
    cyc(); #1;
    accept(4'd10, 3'b000, 1'b0);
    check("sys_nocommit", {commit, pc_we}, 2'b00);
    in_valid = 1'b1;
    in_op    = 4'd0;
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      check("halt_state", {halted, in_ready, commit}, 3'b100);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("halt_rst", {halted, in_ready}, 2'b01);
    cyc();
    rst = 1'b1;
    cyc(); #1;
    check("post_rst_ready", in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
